video_timing_ctrl: RTL and testbench
====================================

// Module: video_timing_ctrl
// PURPOSE
//  Sequences the HDMI/DVI transmitter: generates 640x480@60 raster timing from pix_clk.
//  Issues pixel coordinates to the renderer, then re-aligns hsync/vsync/vde with the
//  renderer's RGB after a fixed latency. Drives hdmi_tx_simple red/green/blue/hsync/vsync/vde.
//  Provides clean start/stop at frame boundaries and a vblank strobe for game-logic updates.
// PARAMETERS
//  H_ACTIVE 640 visible px/line; H_FP 16; H_SYNC 96; H_BP 48 (H_TOTAL=800)
//  V_ACTIVE 480 visible lines;   V_FP 10; V_SYNC 2;  V_BP 33 (V_TOTAL=525)
//  SYNC_POL 0   active level of hsync/vsync (0 = active-low, as 640x480 requires)
//  LATENCY  2   renderer cycles from draw_x/draw_y to matching red_in/green_in/blue_in (0..7)
// PORTS
//  pix_clk     in  1  pixel clock (25.175 MHz); sole clock
//  rst         in  1  asynchronous, active-high reset
//  en          in  1  level request to run raster output
//  red_in      in  8  renderer red, LATENCY cycles after its coordinate
//  green_in    in  8  renderer green
//  blue_in     in  8  renderer blue
//  draw_x      out 10 current h counter (0..H_TOTAL-1)
//  draw_y      out 10 current v counter (0..V_TOTAL-1)
//  pix_req     out 1  draw_x/draw_y is inside the active area and running
//  frame_start out 1  1-cycle pulse when counters are (0,0) in RUN
//  vblank      out 1  1-cycle pulse when counters are (0,V_ACTIVE) in RUN
//  running     out 1  state is RUN or STOPPING
//  red,green,blue out 8 each  to hdmi_tx_simple; forced 0 when vde=0
//  hsync,vsync out 1  to hdmi_tx_simple, polarity per SYNC_POL
//  vde         out 1  to hdmi_tx_simple, video data enable
// BEHAVIOUR
//  Reset: state IDLE, counters 0, pix_req/frame_start/vblank/running/vde=0, rgb=0,
//   hsync=vsync=~SYNC_POL; all delay-line stages cleared to the inactive values.
//  FSM: IDLE -(en)-> WARMUP -(LATENCY+1 cycles elapsed)-> RUN -(!en)-> STOPPING
//   -(last pixel of frame: h=H_TOTAL-1, v=V_TOTAL-1)-> IDLE. STOPPING -(en)-> RUN (cancel).
//   IDLE/WARMUP: counters held at 0, raw syncs inactive, raw vde=0.
//   RUN/STOPPING: h increments each cycle; at H_TOTAL-1 wraps to 0 and v increments;
//   v wraps to 0 at V_TOTAL-1 when h wraps. Counters 10 bit, never exceed TOTAL-1.
//  Raw decode from counters, combinational (running states only):
//   hs_raw active for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751]
//   vs_raw active for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [490,491]
//   de_raw = (h<H_ACTIVE)&&(v<V_ACTIVE); pix_req = de_raw.
//  Alignment: {hs,vs,de}_raw pass a LATENCY-deep shift register, then one output register
//   that also samples rgb_in. Coordinate issued at cycle t -> hsync/vsync/vde/rgb for it
//   appear at cycle t+LATENCY+1. rgb = de_delayed ? rgb_in : 0.
//  frame_start/vblank are combinational from state+counters (no delay); vblank marks
//   start of the vertical blanking interval for sprite/scroll updates.
//  en deassert mid-frame: frame completes fully; IDLE entered after (H_TOTAL-1,V_TOTAL-1);
//   delay line flushes to inactive values naturally over LATENCY+1 cycles.
//  en pulse in WARMUP is ignored (WARMUP always completes to RUN, then STOPPING if !en).
//  rst asserted mid-frame: immediate return to reset values, no partial-frame completion.
// STRUCTURE
//  Package video_timing_pkg: 640x480 timing constants, H_TOTAL/V_TOTAL, CNT_W=10,
//   enum vt_state_t {VT_IDLE, VT_WARMUP, VT_RUN, VT_STOPPING}.
//  One sub-module: sync_delay_line (parameter DEPTH, 3-bit data, reset value input) for
//   the aligned sync/de pipeline; counters, FSM and output register stay in the top.
// TESTING
//  Reset then en=1 -> running rises after LATENCY+1 cycles; first frame_start with draw (0,0).
//  Free run, LATENCY=2 -> hsync low 96 cycles/800; vsync low lines 490-491 (1600 cycles);
//   vde high 640x480=307200 cycles/frame; frame period 420000 cycles.
//  red_in=draw_x[7:0] delayed by 2 cycles -> red at each vde-high cycle equals its column;
//   red=0 whenever vde=0 even with red_in=8'hFF.
//  en=0 at (100,200) -> outputs continue through (799,524), state IDLE next cycle, no
//   further frame_start; re-raise en during STOPPING -> no gap, next frame_start at (0,0).
//  rst pulse at (300,100) -> same cycle hsync=vsync=1, vde=0, rgb=0, draw (0,0).
//  SYNC_POL=1, LATENCY=0 -> sync pulses active-high; vde edge 1 cycle after pix_req edge.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared timing constants and FSM state type for the 640x480@60 raster generator.
package video_timing_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam int unsigned DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int unsigned CNT_W = 10;

    typedef enum logic [1:0] {
        VT_IDLE,
        VT_WARMUP,
        VT_RUN,
        VT_STOPPING
    } vt_state_t;

endpackage

// File: rtl/sync_delay_line.sv
// DEPTH-stage shift register for {hsync, vsync, de}; reset loads every stage with rst_val_i.
module sync_delay_line #(
    parameter int unsigned DEPTH = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [2:0] rst_val_i,
    input  logic [2:0] d_i,
    output logic [2:0] q_o
);

    if (DEPTH == 0) begin : g_bypass
        logic unused;
        assign unused = ^{clk_i, rst_i, rst_val_i};
        assign q_o    = d_i;
    end else begin : g_shift
        logic [2:0] stage_q [DEPTH];

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= rst_val_i;
                end
            end else begin
                stage_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/video_timing_ctrl.sv
// Raster timing generator: issues pixel coordinates to the renderer and re-aligns
// hsync/vsync/vde with the renderer's RGB after LATENCY cycles.
module video_timing_ctrl
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned LATENCY  = 2
) (
    input  logic             pix_clk,
    input  logic             rst,
    input  logic             en,
    input  logic [7:0]       red_in,
    input  logic [7:0]       green_in,
    input  logic [7:0]       blue_in,
    output logic [CNT_W-1:0] draw_x,
    output logic [CNT_W-1:0] draw_y,
    output logic             pix_req,
    output logic             frame_start,
    output logic             vblank,
    output logic             running,
    output logic [7:0]       red,
    output logic [7:0]       green,
    output logic [7:0]       blue,
    output logic             hsync,
    output logic             vsync,
    output logic             vde
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [2:0]       WARM_LAST = 3'(LATENCY);

    vt_state_t        state_q, state_d;
    logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
    logic [2:0]       warm_q, warm_d;
    logic             run_state, last_px;
    logic             hs_raw, vs_raw, de_raw;
    logic [2:0]       sync_dly;

    logic       hsync_q, vsync_q, vde_q;
    logic [7:0] red_q, green_q, blue_q;

    assign run_state = (state_q == VT_RUN) || (state_q == VT_STOPPING);
    assign last_px   = (h_q == H_LAST) && (v_q == V_LAST);

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        warm_d  = warm_q;
        unique case (state_q)
            VT_IDLE: begin
                h_d    = '0;
                v_d    = '0;
                warm_d = '0;
                if (en) state_d = VT_WARMUP;
            end
            // Holds off RUN until the delay line is primed; en is not looked at here.
            VT_WARMUP: begin
                if (warm_q == WARM_LAST) state_d = VT_RUN;
                else                     warm_d  = warm_q + 3'd1;
            end
            VT_RUN: begin
                if (!en) state_d = VT_STOPPING;
            end
            VT_STOPPING: begin
                if (en)           state_d = VT_RUN;
                else if (last_px) state_d = VT_IDLE;
            end
            default: state_d = VT_IDLE;
        endcase

        if (run_state) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            state_q <= VT_IDLE;
            h_q     <= '0;
            v_q     <= '0;
            warm_q  <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            warm_q  <= warm_d;
        end
    end

    assign de_raw = run_state && (h_q < H_ACT) && (v_q < V_ACT);
    assign hs_raw = (run_state && (h_q >= HS_FIRST) && (h_q <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
    assign vs_raw = (run_state && (v_q >= VS_FIRST) && (v_q <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;

    sync_delay_line #(
        .DEPTH (LATENCY)
    ) u_sync_delay_line (
        .clk_i     (pix_clk),
        .rst_i     (rst),
        .rst_val_i ({~SYNC_POL, ~SYNC_POL, 1'b0}),
        .d_i       ({hs_raw, vs_raw, de_raw}),
        .q_o       (sync_dly)
    );

    // Final stage lines up the delayed sync/de with the renderer's RGB for the same pixel.
    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            vde_q   <= 1'b0;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else begin
            hsync_q <= sync_dly[2];
            vsync_q <= sync_dly[1];
            vde_q   <= sync_dly[0];
            red_q   <= sync_dly[0] ? red_in   : '0;
            green_q <= sync_dly[0] ? green_in : '0;
            blue_q  <= sync_dly[0] ? blue_in  : '0;
        end
    end

    assign draw_x      = h_q;
    assign draw_y      = v_q;
    assign pix_req     = de_raw;
    assign running     = run_state;
    assign frame_start = (state_q == VT_RUN) && (h_q == '0) && (v_q == '0);
    assign vblank      = (state_q == VT_RUN) && (h_q == '0) && (v_q == V_ACT);

    assign hsync = hsync_q;
    assign vsync = vsync_q;
    assign vde   = vde_q;
    assign red   = red_q;
    assign green = green_q;
    assign blue  = blue_q;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Randomized bench for video_timing_ctrl: two shrunken-raster instances with different
// LATENCY/SYNC_POL, a frame-position reference model and a queue-based scoreboard.
module tb_video_timing_ctrl;

    logic pix_clk = 1'b0;
    always #5 pix_clk = ~pix_clk;

    logic rst = 1'b1;
    logic en  = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge pix_clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int HA  = (g == 0) ? 16 : 10;
        localparam int HF  = (g == 0) ? 2  : 1;
        localparam int HS  = (g == 0) ? 4  : 3;
        localparam int HB  = (g == 0) ? 3  : 2;
        localparam int VA  = (g == 0) ? 8  : 6;
        localparam int VF  = (g == 0) ? 2  : 1;
        localparam int VS  = (g == 0) ? 2  : 1;
        localparam int VB  = (g == 0) ? 3  : 2;
        localparam int L   = (g == 0) ? 2  : 0;
        localparam bit POL = (g == 0) ? 1'b0 : 1'b1;
        localparam int HT  = HA + HF + HS + HB;
        localparam int VT  = VA + VF + VS + VB;
        localparam int FT  = HT * VT;

        logic [7:0] red_in = 8'h00, green_in = 8'h00, blue_in = 8'h00;
        logic [7:0] red, green, blue;
        logic [9:0] draw_x, draw_y;
        logic       pix_req, frame_start, vblank, running, hsync, vsync, vde;

        video_timing_ctrl #(
            .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
            .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
            .SYNC_POL (POL), .LATENCY (L)
        ) u_dut (
            .pix_clk     (pix_clk),
            .rst         (rst),
            .en          (en),
            .red_in      (red_in),
            .green_in    (green_in),
            .blue_in     (blue_in),
            .draw_x      (draw_x),
            .draw_y      (draw_y),
            .pix_req     (pix_req),
            .frame_start (frame_start),
            .vblank      (vblank),
            .running     (running),
            .red         (red),
            .green       (green),
            .blue        (blue),
            .hsync       (hsync),
            .vsync       (vsync),
            .vde         (vde)
        );

        // {x, y, pix_req, frame_start, vblank, running} for the current cycle
        logic [23:0] imm_q[$];
        // {hsync, vsync, vde, r, g, b} expected LATENCY+1 cycles after its coordinate
        logic [26:0] dly_q[$];
        logic [23:0] rend_q[$];

        // Model: mode 0 idle, 1 warm-up, 2 run, 3 stopping; pos = linear pixel index in frame.
        initial begin : p_model
            int          mode, pos, warm, x, y;
            bit          en_s, rst_s, run, act, hs_on, vs_on, fs, vb;
            logic [7:0]  b;
            logic [23:0] pix;
            logic [26:0] idle_rec;
            mode = 0;
            pos  = 0;
            warm = 0;
            idle_rec = {~POL, ~POL, 1'b0, 24'h0};
            repeat (L) rend_q.push_back(24'hFFFFFF);
            forever begin
                @(posedge pix_clk);
                en_s  = en;
                rst_s = rst;
                #2;
                if (rst_s || rst) begin
                    mode = 0;
                    pos  = 0;
                    warm = 0;
                    dly_q.delete();
                    repeat (L + 1) dly_q.push_back(idle_rec);
                end else begin
                    case (mode)
                        0: if (en_s) begin mode = 1; warm = L + 1; end
                        1: begin
                            warm--;
                            if (warm == 0) mode = 2;
                        end
                        2: begin
                            pos = (pos + 1) % FT;
                            if (!en_s) mode = 3;
                        end
                        default: begin
                            if (en_s) begin
                                mode = 2;
                                pos  = (pos + 1) % FT;
                            end else if (pos == FT - 1) begin
                                mode = 0;
                                pos  = 0;
                            end else begin
                                pos++;
                            end
                        end
                    endcase
                end

                x     = pos % HT;
                y     = pos / HT;
                run   = (mode >= 2);
                act   = run && x < HA && y < VA;
                hs_on = run && x >= HA + HF && x < HA + HF + HS;
                vs_on = run && y >= VA + VF && y < VA + VF + VS;
                fs    = (mode == 2) && (pos == 0);
                vb    = (mode == 2) && (pos == VA * HT);
                b     = 8'($urandom);
                imm_q.push_back({10'(x), 10'(y), act, fs, vb, run});
                dly_q.push_back({hs_on ? POL : ~POL, vs_on ? POL : ~POL, act,
                                 act ? {8'(x), 8'(y), b} : 24'h0});

                // Renderer answers the DUT's coordinate L cycles later; garbage outside active.
                if (pix_req) pix = {draw_x[7:0], draw_y[7:0], b};
                else         pix = {8'hFF, 8'($urandom), 8'($urandom)};
                rend_q.push_back(pix);
                if (rend_q.size() > L) {red_in, green_in, blue_in} = rend_q.pop_front();
            end
        end

        initial begin : p_monitor
            logic [23:0] exp_i, got_i;
            logic [26:0] exp_d, got_d;
            forever begin
                @(negedge pix_clk);
                if (imm_q.size() > 0) begin
                    exp_i = imm_q.pop_front();
                    got_i = {draw_x, draw_y, pix_req, frame_start, vblank, running};
                    checks++;
                    if (got_i !== exp_i) begin
                        failures++;
                        $display("FAIL coord_flags inst=%0d cyc=%0d got x=%0d y=%0d req/fs/vb/run=%b exp x=%0d y=%0d req/fs/vb/run=%b",
                                 g, cyc, got_i[23:14], got_i[13:4], got_i[3:0],
                                 exp_i[23:14], exp_i[13:4], exp_i[3:0]);
                    end
                end
                if (dly_q.size() >= L + 2) begin
                    exp_d = dly_q.pop_front();
                    got_d = {hsync, vsync, vde, red, green, blue};
                    checks++;
                    if (got_d !== exp_d) begin
                        failures++;
                        $display("FAIL sync_de_rgb inst=%0d cyc=%0d got hs/vs/de=%b rgb=%h exp hs/vs/de=%b rgb=%h",
                                 g, cyc, got_d[26:24], got_d[23:0], exp_d[26:24], exp_d[23:0]);
                    end
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge pix_clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        cycles(3);
        rst = 1'b0;
        cycles(2);
        en = 1'b1;
        cycles(1000);
        en = 1'b0;
        cycles(450);
        // single-cycle request: warm-up still completes, then one full frame in STOPPING
        en = 1'b1;
        cycles(1);
        en = 1'b0;
        cycles(900);
        for (int s = 0; s < 80 && failures < 100; s++) begin
            if ($urandom_range(0, 7) == 0) begin
                rst = 1'b1;
                cycles(int'($urandom_range(1, 3)));
                rst = 1'b0;
            end
            en = 1'($urandom_range(0, 1));
            cycles(int'($urandom_range(1, 300)));
        end
        en = 1'b0;
        cycles(900);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
